fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the decoder.
- Holds the PC and issues word reads to a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned instructions in a 2-entry FIFO and presents them to decode as (ir, pc) with a valid/ready handshake.
- Accepts branch/jump redirects and a halt request from later stages.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues 1-cycle-latency reads to instruction
// memory and hands (ir, pc) pairs to decode through a 2-entry buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic        fetch_stopped
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic        inflight;
  logic [31:0] inflight_pc;
  logic [31:0] fifo_ir [2];
  logic [31:0] fifo_pc [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        stored_nonempty;
  logic        pop;
  logic        push_store;
  logic        pop_store;

  always_comb begin
    state_nxt = state;
    if (state == RUN && halt) state_nxt = HALTED;
  end

  // Credits cover stored entries plus the response still returning, so the
  // buffer can never overflow.
  assign imem_req  = !rst && (state == RUN) && !halt && !redirect &&
                     ((count + {1'b0, inflight}) < 2'd2);
  assign imem_addr = pc;

  // Handshake: an instruction transfers on a cycle where id_valid && id_ready.
  // id_valid never depends on id_ready; redirect masks it in the flush cycle.
  // A response arriving into an empty buffer is presented directly this cycle.
  assign stored_nonempty = (count != 2'd0);
  assign id_valid  = (stored_nonempty || inflight) && !redirect;
  assign id_ir     = stored_nonempty ? fifo_ir[rd_ptr] : (inflight ? imem_rdata : NOP);
  assign id_pc     = stored_nonempty ? fifo_pc[rd_ptr] : (inflight ? inflight_pc : 32'h0);
  assign pop       = id_valid && id_ready;
  assign pop_store = pop && stored_nonempty;
  // The returning word is stored unless it bypassed straight into decode.
  assign push_store = inflight && !redirect && (stored_nonempty || !pop);

  assign fetch_stopped = (state == HALTED) && !stored_nonempty && !inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
      if (redirect) begin
        pc     <= {redirect_pc[31:2], 2'b00};
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push_store) wr_ptr <= ~wr_ptr;
        if (pop_store)  rd_ptr <= ~rd_ptr;
        case ({push_store, pop_store})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_store) begin
      fifo_ir[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr] <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a queue-based model of outstanding
// fetches checked every cycle, plus hand-computed literal pins.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_ir;
  logic [31:0] id_pc;
  logic        fetch_stopped;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .id_ready(id_ready), .id_valid(id_valid), .id_ir(id_ir), .id_pc(id_pc),
    .fetch_stopped(fetch_stopped)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h5A00_0000;
  endfunction

  // synchronous instruction memory, 1-cycle latency
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: every fetch requested before this cycle and not yet consumed, in order,
  // as {ir, pc}. The oldest is what decode must see.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_live = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pc     = RESET_PC;
      m_halted = 1'b0;
      m_live   = 1'b1;
    end else if (m_live) begin
      automatic logic req = !m_halted && !halt && !redirect && (exp_q.size() < 2);
      automatic logic pp  = (exp_q.size() > 0) && !redirect && id_ready;
      if (redirect) begin
        exp_q.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pp) void'(exp_q.pop_front());
        if (req) begin
          exp_q.push_back({mem_word(m_pc), m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
      if (halt) m_halted = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_live && !rst) begin
      automatic logic e_req = !m_halted && !halt && !redirect && (exp_q.size() < 2);
      automatic logic ne    = exp_q.size() > 0;
      automatic logic [63:0] hd = ne ? exp_q[0] : {NOP, 32'h0};
      check("model imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check("model imem_addr", imem_addr, m_pc);
      check("model id_valid", {31'b0, id_valid}, {31'b0, ne && !redirect});
      check("model id_ir", id_ir, hd[63:32]);
      check("model id_pc", id_pc, hd[31:0]);
      check("model fetch_stopped", {31'b0, fetch_stopped}, {31'b0, m_halted && !ne});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    check({"pin ", name}, act, exp);
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0; id_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    pin("rst imem_req", {31'b0, imem_req}, 32'h0);
    pin("rst id_valid", {31'b0, id_valid}, 32'h0);
    pin("rst id_ir", id_ir, 32'h0000_0013);
    pin("rst id_pc", id_pc, 32'h0);
    pin("rst fetch_stopped", {31'b0, fetch_stopped}, 32'h0);

    // streaming
    tick(); rst = 1'b0; id_ready = 1'b1;                      // cycle 0
    @(negedge clk);
    pin("c0 imem_req", {31'b0, imem_req}, 32'h1);
    pin("c0 imem_addr", imem_addr, 32'h0);
    tick();                                                    // cycle 1
    @(negedge clk);
    pin("c1 id_valid", {31'b0, id_valid}, 32'h1);
    pin("c1 id_pc", id_pc, 32'h0);
    pin("c1 id_ir", id_ir, 32'hA5FF_FFFF);
    tick(); @(negedge clk); pin("c2 id_pc", id_pc, 32'h4);

    // backpressure
    tick(); id_ready = 1'b0;                                   // cycle 3
    @(negedge clk); pin("c3 id_pc", id_pc, 32'h8);
    tick(); tick();                                            // cycle 5
    @(negedge clk);
    pin("full imem_req", {31'b0, imem_req}, 32'h0);
    pin("full id_pc", id_pc, 32'h8);
    tick(); id_ready = 1'b1;                                   // cycle 6
    @(negedge clk); pin("rel id_pc0", id_pc, 32'h8);
    tick(); @(negedge clk); pin("rel id_pc1", id_pc, 32'hC);
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103;      // cycle 8
    @(negedge clk);
    pin("redir T id_valid", {31'b0, id_valid}, 32'h0);
    pin("redir T id_pc", id_pc, 32'h10);
    pin("redir T imem_req", {31'b0, imem_req}, 32'h0);
    tick(); redirect = 1'b0;                                   // cycle 9
    @(negedge clk);
    pin("redir T+1 id_valid", {31'b0, id_valid}, 32'h0);
    pin("redir T+1 imem_addr", imem_addr, 32'h100);
    tick();                                                    // cycle 10
    @(negedge clk);
    pin("redir T+2 id_valid", {31'b0, id_valid}, 32'h1);
    pin("redir T+2 id_pc", id_pc, 32'h100);
    pin("redir T+2 id_ir", id_ir, 32'hA5FF_FEFF);

    // redirect while stalled with a full buffer
    tick(); id_ready = 1'b0;                                   // cycle 11
    tick(); tick(); redirect = 1'b1; redirect_pc = 32'h40;     // cycle 13
    @(negedge clk); pin("stall redir imem_req", {31'b0, imem_req}, 32'h0);
    tick(); redirect = 1'b0;                                   // cycle 14
    @(negedge clk); pin("stall redir addr", imem_addr, 32'h40);
    tick();                                                    // cycle 15
    @(negedge clk);
    pin("stall redir id_pc", id_pc, 32'h40);
    pin("stall redir id_valid", {31'b0, id_valid}, 32'h1);

    // halt with two buffered entries
    tick();                                                    // cycle 16
    tick(); halt = 1'b1; id_ready = 1'b1;                      // cycle 17
    @(negedge clk);
    pin("halt imem_req", {31'b0, imem_req}, 32'h0);
    pin("halt id_pc0", id_pc, 32'h40);
    tick(); halt = 1'b0;                                       // cycle 18
    @(negedge clk);
    pin("halt id_pc1", id_pc, 32'h44);
    pin("halt not stopped", {31'b0, fetch_stopped}, 32'h0);
    tick(); @(negedge clk);                                    // cycle 19
    pin("halt stopped", {31'b0, fetch_stopped}, 32'h1);
    pin("halt drained", {31'b0, id_valid}, 32'h0);
    repeat (3) tick();
    @(negedge clk);
    pin("halt held", {31'b0, fetch_stopped}, 32'h1);
    pin("halt no req", {31'b0, imem_req}, 32'h0);

    // wrap
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk); pin("restart addr", imem_addr, RESET_PC);
    tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect = 1'b0;
    @(negedge clk); pin("wrap addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clk);
    pin("wrap addr1", imem_addr, 32'h0);
    pin("wrap id_pc", id_pc, 32'hFFFF_FFFC);
    pin("wrap id_ir", id_ir, 32'h5A00_0003);

    // reset mid-stream
    repeat (3) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    pin("mid rst id_valid", {31'b0, id_valid}, 32'h0);
    pin("mid rst id_ir", id_ir, 32'h0000_0013);
    pin("mid rst addr", imem_addr, RESET_PC);
    pin("mid rst req", {31'b0, imem_req}, 32'h1);
    tick(); @(negedge clk); pin("mid rst id_pc", id_pc, RESET_PC);

    // halt and redirect together
    tick(); halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk); pin("hr id_valid", {31'b0, id_valid}, 32'h0);
    tick(); halt = 1'b0; redirect = 1'b0;
    @(negedge clk);
    pin("hr stopped", {31'b0, fetch_stopped}, 32'h1);
    pin("hr no req", {31'b0, imem_req}, 32'h0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
